// File: rtl/can_rx_data_collector.sv
// rtl/can_rx_data_collector.sv - CAN/CAN FD receive data-field collector with 64-byte buffer
module can_rx_data_collector #(
  parameter int MAX_BYTES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [6:0] data_len_i,
  input  logic       rtr_i,
  input  logic       bit_valid_i,
  input  logic       bit_i,
  input  logic       abort_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [6:0] byte_cnt_o,
  output logic [6:0] len_o,
  input  logic [5:0] rd_addr_i,
  output logic [7:0] rd_data_o
);

  localparam logic [6:0] MAX_LEN = 7'(MAX_BYTES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  sr;
  logic [2:0]  bit_cnt;
  logic [6:0]  eff_len;
  logic        bit_take;
  logic        byte_last_bit;
  logic [7:0]  byte_new;
  logic        wr_en;
  logic [7:0]  mem [MAX_BYTES];

  // Effective length: remote frames carry no data, oversize DLC values clamp to the buffer depth
  always_comb begin
    eff_len = 7'd0;
    if (!rtr_i) begin
      eff_len = (data_len_i > MAX_LEN) ? MAX_LEN : data_len_i;
    end
  end

  // A data bit is only accepted while collecting and when nothing of higher priority is present
  always_comb begin
    bit_take      = (state == S_COLLECT) && bit_valid_i && !abort_i && !start_i;
    byte_last_bit = (bit_cnt == 3'd7);
    byte_new      = {sr[6:0], bit_i};
    wr_en         = bit_take && byte_last_bit;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: abort beats start, start beats bit reception
  always_comb begin
    state_nxt = state;
    if (abort_i) begin
      state_nxt = S_IDLE;
    end else if (start_i) begin
      state_nxt = (eff_len == 7'd0) ? S_DONE : S_COLLECT;
    end else begin
      case (state)
        S_IDLE:    state_nxt = S_IDLE;
        S_COLLECT: begin
          if (wr_en && ((byte_cnt_o + 7'd1) == len_o)) begin
            state_nxt = S_DONE;
          end
        end
        S_DONE:    state_nxt = S_IDLE;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  // Output decode from the current state
  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    case (state)
      S_COLLECT: busy_o = 1'b1;
      S_DONE:    done_o = 1'b1;
      default:   ;
    endcase
  end

  // Frame datapath: length latch, byte/bit counters and MSB-first shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_o      <= 7'd0;
      byte_cnt_o <= 7'd0;
      bit_cnt    <= 3'd0;
      sr         <= 8'd0;
    end else if (abort_i) begin
      // Counters and length are held for the host to inspect; the partial byte is dropped on restart
      len_o      <= len_o;
    end else if (start_i) begin
      len_o      <= eff_len;
      byte_cnt_o <= 7'd0;
      bit_cnt    <= 3'd0;
      sr         <= 8'd0;
    end else if (bit_take) begin
      sr      <= byte_new;
      bit_cnt <= bit_cnt + 3'd1;
      if (byte_last_bit) begin
        byte_cnt_o <= byte_cnt_o + 7'd1;
      end
    end
  end

  // Receive buffer; byte_cnt_o stays below 64 while collecting so six index bits suffice
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_BYTES; i++) begin
        mem[i] <= 8'd0;
      end
    end else if (wr_en) begin
      mem[byte_cnt_o[5:0]] <= byte_new;
    end
  end

  // Registered read port; a same-edge write is seen one read later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_o <= 8'd0;
    end else begin
      rd_data_o <= mem[rd_addr_i];
    end
  end

endmodule

// File: tb/tb_can_rx_data_collector.sv
// tb/tb_can_rx_data_collector.sv - scoreboard bench for can_rx_data_collector
module tb_can_rx_data_collector;

  logic       clk;
  logic       rst_n;
  logic       start_i;
  logic [6:0] data_len_i;
  logic       rtr_i;
  logic       bit_valid_i;
  logic       bit_i;
  logic       abort_i;
  logic       busy_o;
  logic       done_o;
  logic [6:0] byte_cnt_o;
  logic [6:0] len_o;
  logic [5:0] rd_addr_i;
  logic [7:0] rd_data_o;

  typedef struct {
    logic [5:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_mem [64];
  int         wr_idx;
  int         n_checks;
  int         n_fail;

  can_rx_data_collector #(.MAX_BYTES(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .data_len_i  (data_len_i),
    .rtr_i       (rtr_i),
    .bit_valid_i (bit_valid_i),
    .bit_i       (bit_i),
    .abort_i     (abort_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .byte_cnt_o  (byte_cnt_o),
    .len_o       (len_o),
    .rd_addr_i   (rd_addr_i),
    .rd_data_o   (rd_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change on the falling edge; outputs are observed there too, half a cycle after the rising edge
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_start(input logic [6:0] len, input logic rtr);
    start_i    = 1'b1;
    data_len_i = len;
    rtr_i      = rtr;
    tick();
    start_i    = 1'b0;
    rtr_i      = 1'b0;
    wr_idx     = 0;
  endtask

  task automatic send_bit(input logic b, input int gap);
    bit_valid_i = 1'b1;
    bit_i       = b;
    tick();
    bit_valid_i = 1'b0;
    for (int g = 0; g < gap; g++) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    exp_t e;
    for (int i = 7; i >= 0; i--) send_bit(b[i], (i == 0) ? 0 : gap);
    e.addr = 6'(wr_idx);
    e.data = b;
    exp_q.push_back(e);
    model_mem[wr_idx] = b;
    wr_idx++;
  endtask

  task automatic read_byte(input logic [5:0] a, output logic [7:0] d);
    rd_addr_i = a;
    tick();
    d = rd_data_o;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_o); end
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done_o); end
    n_checks++; if (byte_cnt_o !== 7'd0) begin n_fail++; $display("FAIL reset_byte_cnt got %0d want 0", byte_cnt_o); end
    n_checks++; if (len_o !== 7'd0) begin n_fail++; $display("FAIL reset_len got %0d want 0", len_o); end
    n_checks++; if (rd_data_o !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data got %h want 00", rd_data_o); end
    read_byte(6'd37, d);
    n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL reset_mem37 got %h want 00", d); end
  endtask

  task automatic test_classic();
    exp_t e;
    logic [7:0] d;
    do_start(7'd8, 1'b0);
    n_checks++; if (len_o !== 7'd8) begin n_fail++; $display("FAIL classic_len got %0d want 8", len_o); end
    n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL classic_busy got %b want 1", busy_o); end
    for (int k = 1; k <= 8; k++) begin
      send_byte(8'(k), 0);
      if (k < 8) begin
        n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL classic_early_done byte %0d got %b want 0", k, done_o); end
      end
    end
    n_checks++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL classic_done got %b want 1", done_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL classic_busy_end got %b want 0", busy_o); end
    n_checks++; if (byte_cnt_o !== 7'd8) begin n_fail++; $display("FAIL classic_byte_cnt got %0d want 8", byte_cnt_o); end
    tick();
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL classic_done_width got %b want 0", done_o); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      read_byte(e.addr, d);
      n_checks++; if (d !== e.data) begin n_fail++; $display("FAIL classic_rd addr %0d got %h want %h", e.addr, d, e.data); end
    end
  endtask

  task automatic test_fd_max();
    exp_t e;
    logic [7:0] d;
    do_start(7'd64, 1'b0);
    n_checks++; if (len_o !== 7'd64) begin n_fail++; $display("FAIL fd_len got %0d want 64", len_o); end
    for (int k = 0; k < 64; k++) send_byte(8'(k), 1);
    n_checks++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL fd_done got %b want 1", done_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL fd_busy got %b want 0", busy_o); end
    n_checks++; if (byte_cnt_o !== 7'd64) begin n_fail++; $display("FAIL fd_byte_cnt got %0d want 64", byte_cnt_o); end
    tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      read_byte(e.addr, d);
      n_checks++; if (d !== e.data) begin n_fail++; $display("FAIL fd_rd addr %0d got %h want %h", e.addr, d, e.data); end
    end
  endtask

  task automatic test_zero_rtr();
    logic [7:0] d;
    logic [6:0] lens [2];
    logic       rtrs [2];
    lens[0] = 7'd12; rtrs[0] = 1'b1;
    lens[1] = 7'd0;  rtrs[1] = 1'b0;
    for (int r = 0; r < 2; r++) begin
      do_start(lens[r], rtrs[r]);
      n_checks++; if (len_o !== 7'd0) begin n_fail++; $display("FAIL zero%0d_len got %0d want 0", r, len_o); end
      n_checks++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL zero%0d_done got %b want 1", r, done_o); end
      n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL zero%0d_busy got %b want 0", r, busy_o); end
      send_bit(1'b1, 0);
      n_checks++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL zero%0d_after got done %b busy %b want 0 0", r, done_o, busy_o); end
      for (int a = 0; a < 8; a++) begin
        read_byte(6'(a), d);
        n_checks++; if (d !== model_mem[a]) begin n_fail++; $display("FAIL zero%0d_keep addr %0d got %h want %h", r, a, d, model_mem[a]); end
      end
    end
  endtask

  task automatic test_clamp();
    exp_t e;
    logic [7:0] d;
    do_start(7'd100, 1'b0);
    n_checks++; if (len_o !== 7'd64) begin n_fail++; $display("FAIL clamp_len got %0d want 64", len_o); end
    for (int k = 0; k < 64; k++) send_byte(8'((k * 7 + 3) & 8'hff), 0);
    n_checks++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL clamp_done got %b want 1", done_o); end
    n_checks++; if (byte_cnt_o !== 7'd64) begin n_fail++; $display("FAIL clamp_byte_cnt got %0d want 64", byte_cnt_o); end
    for (int i = 0; i < 8; i++) send_bit(1'b0, 0);
    n_checks++; if (byte_cnt_o !== 7'd64 || busy_o !== 1'b0) begin n_fail++; $display("FAIL clamp_idle_bits got cnt %0d busy %b want 64 0", byte_cnt_o, busy_o); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      read_byte(e.addr, d);
      n_checks++; if (d !== e.data) begin n_fail++; $display("FAIL clamp_rd addr %0d got %h want %h", e.addr, d, e.data); end
    end
  endtask

  task automatic test_abort();
    exp_t e;
    logic [7:0] d;
    do_start(7'd4, 1'b0);
    send_byte(8'h3C, 0);
    for (int i = 0; i < 5; i++) send_bit(i[0], 0);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy_o); end
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL abort_done got %b want 0", done_o); end
    n_checks++; if (byte_cnt_o !== 7'd1) begin n_fail++; $display("FAIL abort_byte_cnt got %0d want 1", byte_cnt_o); end
    n_checks++; if (len_o !== 7'd4) begin n_fail++; $display("FAIL abort_len got %0d want 4", len_o); end
    for (int i = 0; i < 3; i++) send_bit(1'b1, 0);
    n_checks++; if (done_o !== 1'b0 || byte_cnt_o !== 7'd1) begin n_fail++; $display("FAIL abort_idle got done %b cnt %0d want 0 1", done_o, byte_cnt_o); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      read_byte(e.addr, d);
      n_checks++; if (d !== e.data) begin n_fail++; $display("FAIL abort_rd addr %0d got %h want %h", e.addr, d, e.data); end
    end
    do_start(7'd1, 1'b0);
    send_byte(8'hA5, 0);
    n_checks++; if (done_o !== 1'b1 || byte_cnt_o !== 7'd1) begin n_fail++; $display("FAIL abort_restart got done %b cnt %0d want 1 1", done_o, byte_cnt_o); end
    e = exp_q.pop_front();
    read_byte(e.addr, d);
    n_checks++; if (d !== 8'hA5) begin n_fail++; $display("FAIL abort_restart_rd got %h want a5", d); end
  endtask

  task automatic test_collision();
    exp_t e;
    logic [7:0] d;
    logic [7:0] old1;
    old1 = model_mem[1];
    bit_valid_i = 1'b1;
    bit_i       = 1'b1;
    do_start(7'd2, 1'b0);
    bit_valid_i = 1'b0;
    send_byte(8'h12, 0);
    for (int i = 7; i >= 1; i--) send_bit(1'(8'h34 >> i), 0);
    rd_addr_i   = 6'd1;
    bit_valid_i = 1'b1;
    bit_i       = 1'b0;
    tick();
    bit_valid_i = 1'b0;
    model_mem[1] = 8'h34;
    n_checks++; if (rd_data_o !== old1) begin n_fail++; $display("FAIL rw_same_cycle got %h want %h", rd_data_o, old1); end
    n_checks++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL collision_done got %b want 1", done_o); end
    tick();
    n_checks++; if (rd_data_o !== 8'h34) begin n_fail++; $display("FAIL rw_after_write got %h want 34", rd_data_o); end
    e = exp_q.pop_front();
    read_byte(e.addr, d);
    n_checks++; if (d !== 8'h12) begin n_fail++; $display("FAIL collision_byte0 got %h want 12", d); end
  endtask

  task automatic test_async_reset();
    logic [7:0] d;
    do_start(7'd8, 1'b0);
    send_byte(8'h77, 0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
    rd_addr_i = 6'd0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin n_fail++; $display("FAIL areset_flags got busy %b done %b want 0 0", busy_o, done_o); end
    n_checks++; if (byte_cnt_o !== 7'd0 || len_o !== 7'd0) begin n_fail++; $display("FAIL areset_counts got cnt %0d len %0d want 0 0", byte_cnt_o, len_o); end
    n_checks++; if (rd_data_o !== 8'h00) begin n_fail++; $display("FAIL areset_rd_data got %h want 00", rd_data_o); end
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    for (int a = 0; a < 64; a++) model_mem[a] = 8'h00;
    for (int a = 0; a < 64; a += 21) begin
      read_byte(6'(a), d);
      n_checks++; if (d !== model_mem[a]) begin n_fail++; $display("FAIL areset_mem addr %0d got %h want %h", a, d, model_mem[a]); end
    end
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    wr_idx      = 0;
    rst_n       = 1'b0;
    start_i     = 1'b0;
    data_len_i  = 7'd0;
    rtr_i       = 1'b0;
    bit_valid_i = 1'b0;
    bit_i       = 1'b0;
    abort_i     = 1'b0;
    rd_addr_i   = 6'd0;
    for (int a = 0; a < 64; a++) model_mem[a] = 8'h00;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_classic();
    test_fd_max();
    test_zero_rtr();
    test_clamp();
    test_abort();
    test_collision();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/can_rx_data_collector.md
# can_rx_data_collector

Receive-side data-field stage that sits directly downstream of the DLC decoder in the CAN/CAN FD receiver. It takes the decoded byte count (0–64) and the stream of destuffed, sampled data-field bits, and packs them MSB-first into bytes. It stores the bytes in a 64-byte receive buffer and signals completion to the CRC/frame-control logic. The host-side receive logic reads the buffer through a registered read port.

## Interface
Parameters:
- MAX_BYTES, 64, buffer depth in bytes; fixed at 64 for CAN FD.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  one-cycle pulse at the sample point of the last DLC bit; latches length and begins the data field.
- data_len_i  in  7  decoded byte count from the DLC decoder; sampled only when start_i=1.
- rtr_i  in  1  remote frame flag, sampled with start_i; 1 forces the length to 0.
- bit_valid_i  in  1  one-cycle strobe per sampled, non-stuff data-field bit.
- bit_i  in  1  bit value, qualified by bit_valid_i.
- abort_i  in  1  error, overload or bus-off; cancels reception.
- busy_o  out  1  1 while in COLLECT.
- done_o  out  1  one-cycle pulse when the last byte has been written.
- byte_cnt_o  out  7  number of complete bytes stored in the current frame.
- len_o  out  7  latched effective length for the current frame.
- rd_addr_i  in  6  buffer read address.
- rd_data_o  out  8  buffer byte at rd_addr_i, registered (1-cycle latency).

## Operation
- Effective length: 0 if rtr_i=1; otherwise min(data_len_i, 64). Values 65–127 are clamped to 64.
- States:
  - IDLE: waits for start_i.
  - COLLECT: shifts in bits and writes bytes.
  - DONE: single cycle that drives done_o=1, then returns to IDLE.
- IDLE + start_i:
  - Latch len_o.
  - Clear byte_cnt_o, the bit counter (3 bits) and the shift register.
  - If the effective length is 0, go to DONE; otherwise go to COLLECT.
- COLLECT + bit_valid_i:
  - Shift register <= {sr[6:0], bit_i}. The first received bit becomes bit 7 of the byte.
  - The bit counter increments modulo 8.
  - On the 8th bit, write {sr[6:0], bit_i} to buffer[byte_cnt_o] and increment byte_cnt_o.
  - If the new count equals len_o, go to DONE.
- Priority, highest first:
  1. abort_i: go to IDLE. byte_cnt_o and len_o are held, and the partial byte is discarded.
  2. start_i: restarts from any state, including COLLECT and DONE.
  3. bit_valid_i.
- A bit_valid_i in the same cycle as start_i is ignored.
- bit_valid_i in IDLE or DONE is ignored.
- Buffer contents persist across frames. Bytes beyond len_o keep their old values.
- Buffer writes never exceed index 63, because the clamp guarantees byte_cnt_o ≤ 64.

## Timing
- Reset values:
  - State IDLE; busy_o=0, done_o=0.
  - byte_cnt_o=0, len_o=0, rd_data_o=0.
  - Shift register 0, bit counter 0, all buffer bytes 0x00.
- start_i in cycle t:
  - busy_o=1 from t+1 if the effective length is nonzero.
  - If the length is 0, done_o=1 in t+1 and busy_o stays 0.
- Last bit_valid_i in cycle t: the byte is written and byte_cnt_o=len_o at t+1. done_o=1 and busy_o=0 in t+1.
- done_o is exactly one cycle wide.
- Write/read timing:
  - A byte written at edge t is visible on rd_data_o when rd_addr_i presents it at t+1, i.e. the registered read after the write edge.
  - A same-cycle read and write to the same address returns the old value.
- Back-to-back bit_valid_i on every cycle is supported with no stalls.

## Test plan
- Classic frame: start_i with data_len_i=8, rtr_i=0, then 64 bits forming 0x01..0x08 MSB-first -> done_o pulses one cycle after the 64th bit; byte_cnt_o=8; reads of addr 0..7 return 0x01..0x08.
- FD max: data_len_i=64, bytes 0x00..0x3F streamed with one idle cycle between bits -> done_o after the 512th bit; addr 63 reads 0x3F; busy_o deasserts in the same cycle done_o rises.
- Zero/RTR: start_i with data_len_i=12, rtr_i=1 -> len_o=0, done_o in the next cycle, busy_o never 1, buffer unchanged. Repeat with data_len_i=0, rtr_i=0 -> same result.
- Clamp: data_len_i=100 -> len_o=64; done_o after 512 bits; no write beyond addr 63.
- Abort mid-byte: data_len_i=4, send 13 bits, then abort_i -> IDLE, busy_o=0, no done_o, byte_cnt_o=1. Next start_i with length 1 and 0xA5 -> addr 0=0xA5, done_o after 8 bits.
- Collision/reset:
  - start_i and bit_valid_i in the same cycle -> the bit is ignored and the first byte is built from the following bits.
  - rst_n asserted mid-COLLECT -> all outputs and buffer return to their reset values immediately (asynchronously).
